gf2m_mul_arbiter: RTL and testbench

//  Round-robin arbiter sharing one gf2m_mul instance among NREQ requesters (e.g. inversion,

---
 rtl/gf2m_mul_arbiter.sv | 142 ++++++++++++++
 tb/tb_gf2m_mul_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_mul_arbiter.sv
// gf2m_mul_arbiter: round-robin arbiter that shares one GF(2^m) multiplier
// among NREQ requesters. The winner's operands are latched, the multiplier is
// started, and its product is handed back with a one-cycle ack. A watchdog
// aborts the operation with err=1 and res=0 if the multiplier never answers.
module gf2m_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int m       = 79,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*m-1:0]    req_op_a,
    input  logic [NREQ*m-1:0]    req_op_b,
    output logic [NREQ-1:0]      ack,
    output logic [m-1:0]         res,
    output logic [IDW-1:0]       res_id,
    output logic                 err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [m-1:0]         mul_op_a,
    output logic [m-1:0]         mul_op_b,
    input  logic                 mul_done,
    input  logic [m-1:0]         mul_op_c
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [m-1:0]   result;
    logic           err_r;
    logic [WDW-1:0] wdog;

    logic           pick_vld;
    logic [IDW-1:0] pick_id;
    logic [IDW:0]   cand_sum;
    logic [m-1:0]   sel_a;
    logic [m-1:0]   sel_b;
    logic [IDW:0]   id_inc;
    logic [IDW-1:0] rr_next;

    // Find the first active request scanning upward from the rr pointer, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ))
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            if (!pick_vld && req[cand_sum[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand_sum[IDW-1:0];
            end
        end
    end

    // Route the winner's operand slices to the capture registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_id == IDW'(k)) begin
                sel_a = req_op_a[k*m +: m];
                sel_b = req_op_b[k*m +: m];
            end
        end
    end

    // Pointer moves to the slot just after the requester being served.
    assign id_inc  = {1'b0, cur_id} + (IDW+1)'(1);
    assign rr_next = (id_inc >= (IDW+1)'(NREQ)) ? '0 : id_inc[IDW-1:0];

    // Arbitration FSM, operand capture, watchdog and result capture.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur_id   <= '0;
            mul_op_a <= '0;
            mul_op_b <= '0;
            result   <= '0;
            err_r    <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cur_id   <= pick_id;
                        mul_op_a <= sel_a;
                        mul_op_b <= sel_b;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + WDW'(1);
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (mul_done) begin
                        result <= mul_op_c;
                        err_r  <= 1'b0;
                        state  <= RESP;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        result <= '0;
                        err_r  <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= rr_next;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-hot ack for the served requester, only during the response cycle.
    always_comb begin
        ack = '0;
        for (int k = 0; k < NREQ; k++)
            ack[k] = (state == RESP) && (cur_id == IDW'(k));
    end

    assign busy      = (state != IDLE);
    assign mul_start = (state == ISSUE);
    assign res       = (state == RESP) ? result : '0;
    assign res_id    = (state == RESP) ? cur_id : '0;
    assign err       = (state == RESP) && err_r;

endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// Bench for gf2m_mul_arbiter: behavioural GF(2^79) multiplier with a
// configurable done delay, plus a scoreboard of expected acks.
module tb_gf2m_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int M       = 79;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;
    localparam int D       = 6;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] req_op_a;
    logic [NREQ*M-1:0] req_op_b;
    logic [NREQ-1:0]   ack;
    logic [M-1:0]      res;
    logic [IDW-1:0]    res_id;
    logic              err;
    logic              busy;
    logic              mul_start;
    logic [M-1:0]      mul_op_a;
    logic [M-1:0]      mul_op_b;
    logic              mul_done;
    logic [M-1:0]      mul_op_c;

    gf2m_mul_arbiter #(.NREQ(NREQ), .m(M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_op_a(req_op_a), .req_op_b(req_op_b),
        .ack(ack), .res(res), .res_id(res_id), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_op_c(mul_op_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Carry-less multiply reduced by x^79 + x^9 + 1.
    function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] x;
        logic         c;
        r = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ x;
            c = x[M-1];
            x = x << 1;
            if (c) x = x ^ 79'h201;
        end
        return r;
    endfunction

    // Multiplier model: done is high for one cycle, delay cycles after start.
    int           delay = D;
    bit           hang  = 1'b0;
    int           mcnt  = 0;
    logic [M-1:0] mprod = '0;
    always @(posedge clk) begin
        if (mul_start) begin
            mcnt  <= delay;
            mprod <= gfmul(mul_op_a, mul_op_b);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mul_done = (mcnt == 1) && !hang;
    assign mul_op_c = mul_done ? mprod : ~mprod;

    typedef struct {
        int           id;
        logic [M-1:0] res;
        bit           err;
    } exp_t;

    exp_t         sb[$];
    int           ack_cyc[$];
    int           left[NREQ];
    int           start_cyc = -1;
    logic [M-1:0] opa[NREQ];
    logic [M-1:0] opb[NREQ];
    int           n_checks = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
        opa[i] = a;
        opb[i] = b;
        req_op_a[i*M +: M] = a;
        req_op_b[i*M +: M] = b;
    endtask

    function automatic logic [M-1:0] rnd79();
        return M'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic expect_op(input int i, input bit e);
        exp_t x;
        x.id  = i;
        x.err = e;
        x.res = e ? '0 : gfmul(opa[i], opb[i]);
        sb.push_back(x);
    endtask

    // One cycle: sample at the falling edge, score any ack, release acked requests.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (mul_start) start_cyc = cyc;
        if (ack !== '0) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 128'(ack), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("ack",    128'(ack),    128'(NREQ'(1) << e.id));
                chk("res_id", 128'(res_id), 128'(e.id));
                chk("res",    128'(res),    128'(e.res));
                chk("err",    128'(err),    128'(e.err));
                if (left[e.id] > 0) left[e.id]--;
                if (left[e.id] == 0) req = req & ~(NREQ'(1) << e.id);
            end
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && req == '0 && !busy) && n < budget);
        if (n >= budget) chk("run_budget_pending", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        rst_b    = 1'b0;
        req      = '0;
        req_op_a = '0;
        req_op_b = '0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ack",   128'(ack),       128'(0));
        chk("rst_res",   128'(res),       128'(0));
        chk("rst_id",    128'(res_id),    128'(0));
        chk("rst_err",   128'(err),       128'(0));
        chk("rst_busy",  128'(busy),      128'(0));
        chk("rst_start", 128'(mul_start), 128'(0));
        chk("rst_opa",   128'(mul_op_a),  128'(0));
        chk("rst_opb",   128'(mul_op_b),  128'(0));
        @(negedge clk);
        rst_b = 1'b1;

        // Round robin, all requests held: order 0,1,2,3,0, 9 cycles apart
        for (int i = 0; i < NREQ; i++) set_ops(i, rnd79(), rnd79());
        left = '{2, 1, 1, 1};
        expect_op(0, 0); expect_op(1, 0); expect_op(2, 0); expect_op(3, 0); expect_op(0, 0);
        ack_cyc.delete();
        req = 4'b1111;
        run(200);
        chk("rr_count", 128'(ack_cyc.size()), 128'(5));
        for (int i = 1; i < 5; i++)
            chk("rr_gap", 128'(ack_cyc[i] - ack_cyc[i-1]), 128'(D + 3));

        // Single request: 3*5 = 0xF, exact latency, late operand change ignored
        set_ops(1, 79'h3, 79'h5);
        begin
            exp_t x;
            x.id = 1; x.res = 79'hF; x.err = 1'b0;
            sb.push_back(x);
        end
        left[1] = 1;
        ack_cyc.delete();
        c = cyc;
        req = 4'b0010;
        step();
        req_op_a[1*M +: M] = 79'h7777;
        step();
        chk("single_opa_held", 128'(mul_op_a), 128'(79'h3));
        chk("single_opb_held", 128'(mul_op_b), 128'(79'h5));
        run(50);
        chk("single_start_cyc", 128'(start_cyc), 128'(c + 1));
        chk("single_ack_cyc",   128'(ack_cyc[0]), 128'(c + 2 + D));

        // Move pointer to 3, then req=0101 -> grant 0 then 2
        set_ops(2, rnd79(), rnd79());
        left[2] = 1;
        expect_op(2, 0);
        req = 4'b0100;
        run(50);
        set_ops(0, rnd79(), rnd79());
        set_ops(2, rnd79(), rnd79());
        left[0] = 1; left[2] = 1;
        expect_op(0, 0); expect_op(2, 0);
        ack_cyc.delete();
        req = 4'b0101;
        run(100);
        chk("wrap_count", 128'(ack_cyc.size()), 128'(2));

        // Watchdog timeout: multiplier never answers
        hang = 1'b1;
        set_ops(3, rnd79(), rnd79());
        left[3] = 1;
        expect_op(3, 1);
        ack_cyc.delete();
        req = 4'b1000;
        run(200);
        chk("timeout_ack_cyc", 128'(ack_cyc[0] - start_cyc), 128'(TIMEOUT + 1));
        hang = 1'b0;
        set_ops(0, rnd79(), rnd79());
        left[0] = 1;
        expect_op(0, 0);
        req = 4'b0001;
        run(50);

        // Race: done on the final watchdog cycle wins
        delay = TIMEOUT;
        set_ops(1, rnd79(), rnd79());
        left[1] = 1;
        expect_op(1, 0);
        ack_cyc.delete();
        req = 4'b0010;
        run(200);
        chk("race_ack_cyc", 128'(ack_cyc[0] - start_cyc), 128'(TIMEOUT + 1));
        delay = D;

        // Reset two cycles after mul_start, pointer was 2
        set_ops(2, rnd79(), rnd79());
        left[2] = 1;
        start_cyc = -1;
        req = 4'b0100;
        for (int i = 0; i < 10 && start_cyc < 0; i++) step();
        chk("rst6_started", 128'(start_cyc >= 0), 128'(1));
        s = start_cyc;
        step();
        step();
        chk("rst6_in_wait", 128'(cyc - s), 128'(2));
        rst_b = 1'b0;
        req = '0;
        left[2] = 0;
        #1;
        chk("rst6_busy",  128'(busy),      128'(0));
        chk("rst6_ack",   128'(ack),       128'(0));
        chk("rst6_start", 128'(mul_start), 128'(0));
        chk("rst6_opa",   128'(mul_op_a),  128'(0));
        chk("rst6_res",   128'(res),       128'(0));
        step();
        step();
        rst_b = 1'b1;
        ack_cyc.delete();
        repeat (8) step();
        chk("rst6_no_ack",    128'(ack_cyc.size()), 128'(0));
        chk("rst6_idle_busy", 128'(busy),           128'(0));
        set_ops(0, rnd79(), rnd79());
        set_ops(3, rnd79(), rnd79());
        left[0] = 1; left[3] = 1;
        expect_op(0, 0); expect_op(3, 0);
        req = 4'b1001;
        run(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
